// File: rtl/util_axis_1553_encoder.sv
// util_axis_1553_encoder: AXI-Stream to MIL-STD-1553 Manchester II word encoder (sync, 16 data bits, odd parity).
// Optional UTIL_1553_PARITY_INJECT_EN: s_axis_tuser[1] inverts the transmitted parity bit.
module util_axis_1553_encoder #(
    parameter int clock_speed = 100000000
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [15:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [1:0]  diff,
    output logic        active
);
    localparam int HB = clock_speed / 2000000;
    localparam int HW = HB > 1 ? $clog2(HB) : 1;
    localparam logic [HW-1:0] HB_LAST = HW'(HB - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t      state_q, state_d;
    logic [HW-1:0] hb_q, hb_d;
    logic [5:0]  idx_q, idx_d;
    logic [16:0] sh_q, sh_d;
    logic        cmd_q, cmd_d;
    logic [1:0]  diff_d;
    logic        active_d, tready_d, hs, hb_end, par, lvl;

    assign hs     = s_axis_tvalid && s_axis_tready;
    assign hb_end = hb_q == HB_LAST;
`ifdef UTIL_1553_PARITY_INJECT_EN
    logic unused_tuser;
    assign unused_tuser = ^s_axis_tuser[7:2];
    assign par = ~^s_axis_tdata ^ s_axis_tuser[1];
`else
    logic unused_tuser;
    assign unused_tuser = ^s_axis_tuser[7:1];
    assign par = ~^s_axis_tdata;
`endif

    // tready is only ever high in IDLE or on the final parity cycle, so hs alone means "load next word"
    always_comb begin
        state_d = state_q;
        hb_d    = hb_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        cmd_d   = cmd_q;
        if (hs) begin
            state_d = SYNC;
            hb_d    = '0;
            idx_d   = '0;
            sh_d    = {s_axis_tdata, par};
            cmd_d   = s_axis_tuser[0];
        end else if (state_q != IDLE) begin
            if (hb_end) begin
                hb_d  = '0;
                idx_d = idx_q + 6'd1;
                if (idx_q[0] && idx_q >= 6'd7) sh_d = {sh_q[15:0], 1'b0};
                if (idx_q == 6'd5) state_d = DATA;
                else if (idx_q == 6'd37) state_d = PARITY;
                else if (idx_q == 6'd39) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end else begin
                hb_d = hb_q + 1'b1;
            end
        end
        // first half of a bit carries the complement, second half the bit itself
        lvl      = state_d == SYNC ? (idx_d < 6'd3 ? ~cmd_d : cmd_d) : (idx_d[0] ? sh_d[16] : ~sh_d[16]);
        active_d = state_d != IDLE;
        diff_d   = active_d ? {~lvl, lvl} : 2'b00;
        tready_d = state_d == IDLE || (state_d == PARITY && idx_d == 6'd39 && hb_d == HB_LAST);
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q       <= IDLE;
            hb_q          <= '0;
            idx_q         <= '0;
            sh_q          <= '0;
            cmd_q         <= 1'b0;
            diff          <= 2'b00;
            active        <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            state_q       <= state_d;
            hb_q          <= hb_d;
            idx_q         <= idx_d;
            sh_q          <= sh_d;
            cmd_q         <= cmd_d;
            diff          <= diff_d;
            active        <= active_d;
            s_axis_tready <= tready_d;
        end
    end
endmodule

// File: tb/tb_util_axis_1553_encoder.sv
// tb_util_axis_1553_encoder: randomized self-checking bench comparing every output cycle against a half-bit level model.
module tb_util_axis_1553_encoder;
    localparam int HB = 50;
    localparam int WC = 40 * HB;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic [15:0] tdata = '0;
    logic [7:0]  tuser = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [1:0]  diff;
    logic        active;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];

    util_axis_1553_encoder #(.clock_speed(100000000)) dut (
        .aclk(aclk), .arst(arst), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .diff(diff), .active(active)
    );

    always #5 aclk = ~aclk;

    // expected {active, diff[1], diff[0]} for every cycle of one word, built from its 40 half-bit levels
    function automatic void push_word(input logic [15:0] d, input logic [7:0] u);
        logic [39:0] h;
        logic p, v;
        p = ~^d;
`ifdef UTIL_1553_PARITY_INJECT_EN
        p = p ^ u[1];
`endif
        for (int i = 0; i < 3; i++) begin
            h[i]   = ~u[0];
            h[i+3] = u[0];
        end
        for (int b = 0; b < 17; b++) begin
            v = (b < 16) ? d[15-b] : p;
            h[6+2*b] = ~v;
            h[7+2*b] = v;
        end
        for (int k = 0; k < WC; k++) exp_q.push_back({1'b1, ~h[k/HB], h[k/HB]});
    endfunction

    task automatic capture(input int n);
        repeat (n) begin
            @(negedge aclk);
            obs_q.push_back({active, diff});
        end
    endtask

    task automatic start_word(input logic [15:0] d, input logic [7:0] u);
        int n = 0;
        @(negedge aclk);
        while (tready !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        total++;
        if (tready !== 1'b1) begin
            bad++;
            $display("FAIL tready_timeout: tready=%b want 1", tready);
        end
        tdata = d;
        tuser = u;
        tvalid = 1'b1;
        @(posedge aclk);
        #1 tvalid = 1'b0;
    endtask

    task automatic test_reset;
        int errs = 0;
        arst = 1'b1;
        tvalid = 1'b1;
        tdata = 16'($urandom);
        @(posedge aclk);
        repeat (100) begin
            @(negedge aclk);
            if ({diff, active, tready} !== 4'b0000) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL reset_hold: %0d cycles not quiet, last diff=%b active=%b tready=%b want 00 0 0", errs, diff, active, tready);
        end
        @(posedge aclk);
        #1 arst = 1'b0;
        tvalid = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        total++;
        if ({tready, active, diff} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_release: tready=%b active=%b diff=%b want 1 0 00", tready, active, diff);
        end
    endtask

    task automatic test_word(input string name, input logic [15:0] d, input logic [7:0] u);
        int errs = 0;
        int first = -1;
        exp_q.delete();
        obs_q.delete();
        push_word(d, u);
        exp_q.push_back(3'b000);
        start_word(d, u);
        capture(WC + 1);
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s: data=%h user=%h %0d cycles wrong, first at %0d got %b want %b",
                     name, d, u, errs, first, obs_q[first], exp_q[first]);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) test_word("random_word", 16'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back;
        int errs = 0;
        int first = -1;
        int pulses = 0;
        int n = 0;
        exp_q.delete();
        obs_q.delete();
        push_word(16'h1234, 8'h00);
        push_word(16'hABCD, 8'h01);
        exp_q.push_back(3'b000);
        @(negedge aclk);
        while (tready !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        tdata = 16'h1234;
        tuser = 8'h00;
        tvalid = 1'b1;
        @(posedge aclk);
        #1 tdata = 16'hABCD;
        tuser = 8'h01;
        for (int k = 0; k < 2 * WC + 1; k++) begin
            @(negedge aclk);
            obs_q.push_back({active, diff});
            if (k < 2 * WC && tready === 1'b1) pulses++;
            if (k == WC - 1) begin
                @(posedge aclk);
                #1 tvalid = 1'b0;
            end
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b_wave: %0d cycles wrong, first at %0d got %b want %b", errs, first, obs_q[first], exp_q[first]);
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL b2b_tready: %0d tready cycles, want 2", pulses);
        end
    endtask

    task automatic test_mid_reset;
        start_word(16'($urandom), 8'($urandom));
        repeat (699) @(posedge aclk);
        #1 arst = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        total++;
        if ({diff, active, tready} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset: diff=%b active=%b tready=%b want 00 0 0", diff, active, tready);
        end
        @(posedge aclk);
        #1 arst = 1'b0;
        test_word("after_reset", 16'($urandom), 8'($urandom));
    endtask

    initial begin
        test_reset;
        test_word("word_0000_data", 16'h0000, 8'h00);
        test_word("word_ffff_cmd", 16'hFFFF, 8'h01);
        test_word("word_0001_data", 16'h0001, 8'h00);
        test_word("word_0000_tuser2", 16'h0000, 8'h02);
        test_random;
        test_back_to_back;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/util_axis_1553_encoder.md
# util_axis_1553_encoder

MIL-STD-1553 Manchester II word encoder.
- Accepts 16-bit words on an AXI-Stream slave and drives a differential pair `diff[1:0]`: 3-bit-time sync, 16 data bits MSB first, one odd-parity bit.
- Sits directly upstream of `util_axis_1553_decoder` in the transmit path. Its `diff` output is the stimulus the decoder consumes, and it is the loopback source for decoder benches.

## Interface
- `clock_speed`, default 100000000: `aclk` frequency in Hz. Must be an integer multiple of 2000000.
- `aclk`  in  1  clock; all logic on rising edge.
- `arst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  16  word to transmit.
- `s_axis_tuser`  in  8  bit 0: sync type (1 = command/status, 0 = data). Bit 1: parity inject (see Configuration). Bits 7:2 ignored.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accepted when `tvalid && tready`.
- `diff`  out  2  `diff[0]` positive line, `diff[1]` negative line.
- `active`  out  1  high while a word is on the bus.

## Operation
- `HB = clock_speed/2000000` cycles per half-bit; one bit time = 2*HB. One word = 40*HB cycles.
- States and transitions:
  - IDLE: `diff = 2'b00`, `active = 0`, `tready = 1`. A handshake latches `tdata`/`tuser` into a shift register and enters SYNC.
  - SYNC: 6*HB cycles.
  - DATA: 16 bits, 2*HB cycles each, `tdata[15]` first.
  - PARITY: 2*HB cycles.
- While in SYNC, DATA or PARITY: `diff[1] = ~diff[0]` on every cycle.
- Sync levels on `diff[0]`:
  - Command/status: low 3*HB, then high 3*HB.
  - Data: high 3*HB, then low 3*HB.
- Bit encoding on `diff[0]`:
  - Bit 1: low for HB, then high for HB.
  - Bit 0: high for HB, then low for HB.
  - Mid-bit transition on every bit.
- Parity bit `p = ~^tdata`, so the 17 bits together have odd parity.
- End of PARITY:
  - If a beat is accepted on the final PARITY cycle, go straight to SYNC with the new word. No gap; back-to-back words are contiguous.
  - Otherwise go to IDLE.
- `s_axis_tready = 1` in IDLE, and on the final cycle of PARITY only. 0 at all other times, and during reset.
- Half-bit timer: counts 0..HB-1 and wraps. Width is `$clog2(HB)`, minimum 1 bit. Half-bit index 0..39 is held in a 6-bit counter.
- `tvalid` deasserting while `tready` is low has no effect. The word being transmitted is never modified after acceptance.
- Reset mid-word: on the cycle after `arst` is sampled high, the word is abandoned and the block is in IDLE with all outputs at reset values. Partial words are not resumed.

## Timing
- Reset values: `diff = 2'b00`, `active = 0`, `s_axis_tready = 0`. `tready` rises on the first cycle after `arst` is sampled low.
- All outputs are registered.
- Latency: a handshake on cycle N puts the first sync level on `diff` and `active = 1` at cycle N+1.
- Last parity half-bit ends at cycle N+40*HB. In the no-follow-up case, `diff = 00` and `active = 0` from cycle N+40*HB+1.
- Back-to-back throughput: exactly one word per 40*HB cycles.

## Configuration
- `UTIL_1553_PARITY_INJECT_EN`
  - Defined: `s_axis_tuser[1] = 1` inverts the transmitted parity bit, producing an even-parity word for decoder error-path testing.
  - Not defined: `tuser[1]` is ignored and parity is always odd.

## Test plan
All scenarios use `clock_speed = 100000000`, so HB = 50.
- Reset: hold `arst` 100 cycles with `tvalid = 1` -> `diff = 00`, `active = 0`, `tready = 0` throughout. `tready = 1` on the first cycle after release.
- Word 0x0000, `tuser = 0`:
  - `diff[0]`: high 150 cycles, then low 150.
  - Then 16 data bits, each high 50 / low 50.
  - Then parity 1: low 50 / high 50.
  - `diff[1]` is always the complement. 2000 cycles total, then `diff = 00`.
- Word 0xFFFF, `tuser = 1`: sync low 150 / high 150. Each data bit low 50 / high 50. Parity 1 (low/high).
- Word 0x0001, `tuser = 0`: bit 0 (last data bit) low/high. Parity 0 (high/low). Decoder loopback reports `tdata = 0x0001` with parity OK.
- Back-to-back: 0x1234 then 0xABCD, `tvalid` held high -> second sync starts on the cycle after the first parity ends. `tready` pulses exactly once per 2000 cycles.
- Mid-word reset: assert `arst` at cycle 700 of a word -> next cycle `diff = 00`, `active = 0`. After release, a new word transmits cleanly.
- With `UTIL_1553_PARITY_INJECT_EN` defined: word 0x0000 with `tuser = 2'b10` -> parity half-bits high/low. Decoder flags a parity error.
